operand_loader: RTL
===================

// Module: operand_loader
//
// PURPOSE
//  Upstream input stage of cmplx_mult. Turns the raw handshake switch and the data
//  switches into four captured operand words: re_a, im_a, re_q, im_q.
//  Each debounced 0->1 transition of the handshake switch captures one data word.
//  After the fourth word, the operand set is presented to the multiplier core on a
//  valid/ready handshake. Also drives a word index for the LED/HEX status display.
//
// PARAMETERS
//  WORD_W           8       operand width; equals `WORD_SIZE width
//  DEBOUNCE_CYCLES  500000  consecutive stable synced samples needed to change the
//                           debounced level (10 ms at 50 MHz); legal range >= 1
//
// PORTS
//  clk           in   1       system clock
//  reset         in   1       asynchronous, active-high reset
//  handshake_sw  in   1       raw handshake switch; asynchronous, bouncy
//  data_sw       in   WORD_W  raw data switches; asynchronous
//  re_a, im_a    out  WORD_W  captured operand A, real / imaginary
//  re_q, im_q    out  WORD_W  captured operand Q, real / imaginary
//  out_valid     out  1       operand set complete and stable
//  out_ready     in   1       multiplier core accepts the operand set
//  word_idx      out  2       index of the next word to load: 0=re_a .. 3=im_q
//  overrun       out  1       sticky: an accept arrived while in PRESENT
//
// BEHAVIOUR
//  - Reset value of all outputs and registers is 0. Reset puts the FSM in LD_RE_A,
//    the debounced level at 0 and the debounce counter at 0.
//  - Synchronisers: 2-flop synchroniser on handshake_sw; 2-flop synchroniser on
//    every bit of data_sw.
//  - Debounce counter:
//    - Counter width is $clog2(DEBOUNCE_CYCLES+1).
//    - The counter increments while the synced level differs from the debounced level.
//    - The counter clears to 0 whenever the two levels are equal.
//    - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the
//      counter clears.
//  - Accept pulse: a one-cycle accept pulse occurs on every 0->1 transition of the
//    debounced level. 1->0 transitions produce nothing.
//  - Latency: the capture register updates DEBOUNCE_CYCLES+3 clocks after the first
//    high synchroniser input sample (2 sync, DEBOUNCE_CYCLES count, 1 capture).
//    Asynchronous sampling adds up to 1 clock of jitter.
//  - Capture data: the captured word is the synced data_sw value in the accept cycle.
//  - FSM states: LD_RE_A -> LD_IM_A -> LD_RE_Q -> LD_IM_Q -> PRESENT.
//    - In each LD_* state, accept writes that state's register and advances the FSM.
//    - Without accept, the FSM holds.
//    - word_idx is 0..3 in LD_RE_A..LD_IM_Q and holds at 3 in PRESENT.
//  - PRESENT: out_valid=1, registered. Operand outputs are frozen.
//    - out_valid && out_ready -> LD_RE_A; out_valid is low from the next cycle.
//    - out_ready is ignored outside PRESENT.
//  - Accept in PRESENT: the word is dropped and overrun is set. overrun is cleared
//    only by reset.
//  - Accept and out_ready in the same PRESENT cycle: the handshake completes, the
//    word is dropped and overrun is set. Nothing is loaded into re_a.
//  - Operand registers keep their old values after leaving PRESENT, until each is
//    overwritten.
//  - Switch held high through reset release: the debounced level starts at 0, so it
//    rises after DEBOUNCE_CYCLES. This gives one accept, which loads re_a.
//  - Reset mid-load: all partial words are lost and loading restarts at re_a.
//
// STRUCTURE
//  - Package cmplx_pkg: typedef word_t (logic [WORD_W-1:0]); enum loader_state_t
//    {LD_RE_A, LD_IM_A, LD_RE_Q, LD_IM_Q, PRESENT}.
//  - Sub-module switch_debouncer #(DEBOUNCE_CYCLES): synchroniser, counter, debounced
//    level and rising-edge pulse. One instance, on handshake_sw.
//  - The data synchroniser, FSM and operand registers live in operand_loader.
//
// TESTING  (DEBOUNCE_CYCLES=4, WORD_W=8)
//  1. Load four words 0x03, 0xFE, 0x10, 0x7F, each with a clean 20-cycle handshake
//     pulse. Required: re_a=0x03, im_a=0xFE, re_q=0x10, im_q=0x7F, out_valid=1,
//     word_idx 0,1,2,3 in order.
//  2. Bounce pattern 1,0,1,1,0 then a steady 1 on handshake_sw.
//     Required: exactly one accept, 4+3 clocks after the steady high starts.
//     A high lasting 3 cycles gives no accept.
//  3. Hold out_ready=0 in PRESENT for 50 cycles. Required: out_valid and the operands
//     stay stable. Then a 1-cycle out_ready: out_valid=0 the next cycle, word_idx=0.
//  4. Extra handshake in PRESENT with data 0x55. Required: overrun=1, operands
//     unchanged, overrun survives the next full load.
//  5. Assert reset after two words are loaded. Required: all outputs 0 immediately
//     (asynchronous). The next load starts at re_a.
//  6. Handshake held high across reset release. Required: one accept, re_a = data
//     value, word_idx=1.

Source files
------------

// File: rtl/cmplx_pkg.sv
// Shared types for the complex multiplier front end: operand word and loader states.
package cmplx_pkg;

  localparam int WORD_SIZE = 8;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [2:0] {
    LD_RE_A,
    LD_IM_A,
    LD_RE_Q,
    LD_IM_Q,
    PRESENT
  } loader_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises a bouncy switch, debounces its level and emits a one-cycle pulse
// on each debounced 0->1 transition.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // p0/p1: two-flop synchroniser on the raw switch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // Level changes only after the synced input has disagreed for CNT_MAX counts;
  // rise is registered alongside the level flip so it lines up with the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
        rise  <= ~level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Collects four operand words from the data switches, one per debounced handshake
// press, and presents the complete set to the multiplier core on valid/ready.
module operand_loader
  import cmplx_pkg::*;
#(
  parameter int WORD_W          = WORD_SIZE,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              handshake_sw,
  input  logic [WORD_W-1:0] data_sw,
  output logic [WORD_W-1:0] re_a,
  output logic [WORD_W-1:0] im_a,
  output logic [WORD_W-1:0] re_q,
  output logic [WORD_W-1:0] im_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        word_idx,
  output logic              overrun
);

  logic              accept;
  logic [WORD_W-1:0] data_p0;
  logic [WORD_W-1:0] data_p1;
  loader_state_t     state;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hs_debounce (
    .clk   (clk),
    .reset (reset),
    .sw    (handshake_sw),
    .rise  (accept)
  );

  // p0/p1: two-flop synchroniser on every data switch bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p0 <= '0;
      data_p1 <= '0;
    end else begin
      data_p0 <= data_sw;
      data_p1 <= data_p0;
    end
  end

  // Loader FSM: outputs are registered and move together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LD_RE_A;
      re_a      <= '0;
      im_a      <= '0;
      re_q      <= '0;
      im_q      <= '0;
      out_valid <= 1'b0;
      word_idx  <= 2'd0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        LD_RE_A: if (accept) begin
          re_a     <= data_p1;
          state    <= LD_IM_A;
          word_idx <= 2'd1;
        end
        LD_IM_A: if (accept) begin
          im_a     <= data_p1;
          state    <= LD_RE_Q;
          word_idx <= 2'd2;
        end
        LD_RE_Q: if (accept) begin
          re_q     <= data_p1;
          state    <= LD_IM_Q;
          word_idx <= 2'd3;
        end
        LD_IM_Q: if (accept) begin
          im_q      <= data_p1;
          state     <= PRESENT;
          out_valid <= 1'b1;
        end
        PRESENT: begin
          // A press here has nowhere to go; remember it rather than losing it silently.
          if (accept) overrun <= 1'b1;
          if (out_ready) begin
            state     <= LD_RE_A;
            out_valid <= 1'b0;
            word_idx  <= 2'd0;
          end
        end
        default: begin
          state     <= LD_RE_A;
          out_valid <= 1'b0;
          word_idx  <= 2'd0;
        end
      endcase
    end
  end

endmodule
